// File: rtl/alu_flag_stage.sv
// rtl/alu_flag_stage.sv - registered ADD/NAND/MOV execute stage with carry/zero flags and forwarding
module alu_flag_stage #(
    parameter int          WIDTH      = 16,
    parameter logic [1:0]  FLAG_RESET = 2'b00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opc,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             wb_en,
    output logic             c_flag,
    output logic             z_flag
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDF = 3'b001;
    localparam logic [2:0] OP_ADC  = 3'b010;
    localparam logic [2:0] OP_ADZ  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NDC  = 3'b101;
    localparam logic [2:0] OP_NDZ  = 3'b110;
    localparam logic [2:0] OP_MOV  = 3'b111;

    logic             pend_c;
    logic             pend_z;
    logic             eff_c;
    logic             eff_z;
    logic             accept;
    logic             emit;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nand_res;
    logic [WIDTH-1:0] res;
    logic             res_we;
    logic             new_c;
    logic             new_z;

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign emit     = out_valid && out_ready && !flush;

    // An op still in the output register has not committed yet, so its flags are forwarded.
    assign eff_c = out_valid ? pend_c : c_flag;
    assign eff_z = out_valid ? pend_z : z_flag;

    assign sum      = {1'b0, src1} + {1'b0, src0};
    assign nand_res = ~(src1 & src0);

    always_comb begin
        res    = '0;
        res_we = 1'b0;
        new_c  = eff_c;
        new_z  = eff_z;
        case (opc)
            OP_ADD: begin
                res    = sum[WIDTH-1:0];
                res_we = 1'b1;
            end
            OP_ADDF: begin
                res    = sum[WIDTH-1:0];
                res_we = 1'b1;
                new_c  = sum[WIDTH];
                new_z  = (sum[WIDTH-1:0] == '0);
            end
            OP_ADC: begin
                if (eff_c) begin
                    res    = sum[WIDTH-1:0];
                    res_we = 1'b1;
                    new_c  = sum[WIDTH];
                    new_z  = (sum[WIDTH-1:0] == '0);
                end
            end
            OP_ADZ: begin
                if (eff_z) begin
                    res    = sum[WIDTH-1:0];
                    res_we = 1'b1;
                    new_z  = (sum[WIDTH-1:0] == '0);
                end
            end
            OP_NAND: begin
                res    = nand_res;
                res_we = 1'b1;
                new_z  = (nand_res == '0);
            end
            OP_NDC: begin
                if (eff_c) begin
                    res    = nand_res;
                    res_we = 1'b1;
                    new_z  = (nand_res == '0);
                end
            end
            OP_NDZ: begin
                if (eff_z) begin
                    res    = nand_res;
                    res_we = 1'b1;
                    new_z  = (nand_res == '0);
                end
            end
            OP_MOV: begin
                res    = src0;
                res_we = 1'b1;
            end
            default: begin
                res    = '0;
                res_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            wb_en     <= 1'b0;
            pend_c    <= 1'b0;
            pend_z    <= 1'b0;
            c_flag    <= FLAG_RESET[1];
            z_flag    <= FLAG_RESET[0];
        end else if (flush) begin
            out_valid <= 1'b0;
            pend_c    <= 1'b0;
            pend_z    <= 1'b0;
        end else begin
            if (emit) begin
                c_flag <= pend_c;
                z_flag <= pend_z;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out       <= res;
                wb_en     <= res_we;
                pend_c    <= new_c;
                pend_z    <= new_z;
            end else if (emit) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_flag_stage.sv
// tb/tb_alu_flag_stage.sv - randomized and directed bench for alu_flag_stage against a transaction model
module tb_alu_flag_stage;

    localparam int         W  = 16;
    localparam logic [1:0] FR = 2'b01;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opc;
    logic [W-1:0] src1;
    logic [W-1:0] src0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         wb_en;
    logic         c_flag;
    logic         z_flag;

    int errors = 0;
    int checks = 0;

    // model: committed flags plus the op (if any) sitting in the result slot
    logic         m_valid;
    logic [W-1:0] m_out;
    logic         m_wb;
    logic         m_pc;
    logic         m_pz;
    logic         m_c;
    logic         m_z;

    alu_flag_stage #(.WIDTH(W), .FLAG_RESET(FR)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opc(opc), .src1(src1), .src0(src0),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .wb_en(wb_en), .c_flag(c_flag), .z_flag(z_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = '0;
        m_wb    = 1'b0;
        m_pc    = 1'b0;
        m_pz    = 1'b0;
        m_c     = FR[1];
        m_z     = FR[0];
    endtask

    task automatic model_exec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ec, input logic ez,
                              output logic [W-1:0] r, output logic w, output logic c, output logic z);
        int unsigned  s;
        logic [W-1:0] s16;
        logic         cn;
        logic [W-1:0] nd;
        s   = 32'(a) + 32'(b);
        s16 = s[W-1:0];
        cn  = s[W];
        nd  = ~(a & b);
        r = '0; w = 1'b0; c = ec; z = ez;
        case (op)
            3'd0: begin r = s16; w = 1'b1; end
            3'd1: begin r = s16; w = 1'b1; c = cn; z = (s16 == 0); end
            3'd2: if (ec) begin r = s16; w = 1'b1; c = cn; z = (s16 == 0); end
            3'd3: if (ez) begin r = s16; w = 1'b1; z = (s16 == 0); end
            3'd4: begin r = nd; w = 1'b1; z = (nd == 0); end
            3'd5: if (ec) begin r = nd; w = 1'b1; z = (nd == 0); end
            3'd6: if (ez) begin r = nd; w = 1'b1; z = (nd == 0); end
            default: begin r = b; w = 1'b1; end
        endcase
    endtask

    // One clock: drive at negedge, check in_ready, model the edge, check outputs at next negedge.
    task automatic cycle(input logic iv, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ordy, input logic fl);
        logic         exp_ready;
        logic         ec, ez;
        logic [W-1:0] r;
        logic         w, c, z;
        in_valid = iv; opc = op; src1 = a; src0 = b; out_ready = ordy; flush = fl;
        #1;
        exp_ready = (!m_valid || ordy) && !fl;
        check("in_ready", in_ready, exp_ready);
        ec = m_valid ? m_pc : m_c;
        ez = m_valid ? m_pz : m_z;
        model_exec(op, a, b, ec, ez, r, w, c, z);
        @(posedge clk);
        if (fl) begin
            m_valid = 1'b0;
        end else begin
            if (m_valid && ordy) begin
                m_c = m_pc;
                m_z = m_pz;
                m_valid = 1'b0;
            end
            if (iv && exp_ready) begin
                m_valid = 1'b1;
                m_out = r; m_wb = w; m_pc = c; m_pz = z;
            end
        end
        @(negedge clk);
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("out", out, m_out);
            check("wb_en", wb_en, m_wb);
        end
        check("c_flag", c_flag, m_c);
        check("z_flag", z_flag, m_z);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 16'h8000;
            3:       return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; opc = '0;
        src1 = '0; src0 = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, '0);
        check("rst_wb_en", wb_en, 1'b0);
        check("rst_flags", {c_flag, z_flag}, FR);
        reset = 1'b0;

        cycle(1, 3'd1, 16'hFFFF, 16'h0001, 1, 0);
        check("tp1_out", out, 16'h0000);
        check("tp1_wb", wb_en, 1'b1);
        cycle(0, 3'd0, 0, 0, 1, 0);
        check("tp1_flags", {c_flag, z_flag}, 2'b11);

        cycle(1, 3'd1, 16'h8000, 16'h8000, 1, 0);
        cycle(1, 3'd2, 16'h0003, 16'h0004, 1, 0);
        check("tp2_out", out, 16'h0007);
        check("tp2_wb", wb_en, 1'b1);
        cycle(0, 3'd0, 0, 0, 1, 0);
        check("tp2_flags", {c_flag, z_flag}, 2'b00);

        cycle(1, 3'd5, 16'hFFFF, 16'hFFFF, 1, 0);
        check("tp3_ndc_wb", wb_en, 1'b0);
        check("tp3_ndc_out", out, 16'h0000);
        cycle(1, 3'd4, 16'hFFFF, 16'hFFFF, 1, 0);
        cycle(0, 3'd0, 0, 0, 1, 0);
        check("tp3_flags", {c_flag, z_flag}, 2'b01);

        cycle(1, 3'd7, 16'h1234, 16'hABCD, 0, 0);
        repeat (3) begin
            cycle(1, 3'd0, 16'h5555, 16'h1111, 0, 0);
            check("tp4_hold_out", out, 16'hABCD);
            check("tp4_hold_ready", in_ready, 1'b0);
        end
        cycle(1, 3'd0, 16'h0001, 16'h0002, 1, 0);
        check("tp4_next_out", out, 16'h0003);
        cycle(0, 3'd0, 0, 0, 1, 0);

        cycle(1, 3'd1, 16'hFFFF, 16'h0002, 0, 0);
        cycle(0, 3'd0, 0, 0, 1, 1);
        check("tp5_flush_c", c_flag, 1'b0);
        cycle(1, 3'd2, 16'h0001, 16'h0001, 1, 0);
        check("tp5_adc_wb", wb_en, 1'b0);
        cycle(0, 3'd0, 0, 0, 1, 0);

        cycle(1, 3'd1, 16'hFFFF, 16'hFFFF, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("tp6_out_valid", out_valid, 1'b0);
        check("tp6_out", out, '0);
        check("tp6_wb_en", wb_en, 1'b0);
        check("tp6_flags", {c_flag, z_flag}, FR);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7, 3'($urandom), pick_operand(), pick_operand(),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
